// File: rtl/alu_load_sequencer.sv
// Operand/opcode loader for an ALU: debounced push buttons step a small FSM
// that latches the switch values into operand A, operand B and the opcode.
module alu_load_sequencer #(
   parameter int NB_DATA     = 8,
   parameter int NB_OP       = 6,
   parameter int DBNC_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic [2:0]         i_btn,
   input  logic [NB_DATA-1:0] i_sw_data,
   input  logic [NB_OP-1:0]   i_sw_op,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op,
   output logic [1:0]         o_state,
   output logic               o_ready,
   output logic               o_load
);

   localparam int CNT_W = 24;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_A  = 2'b00,
      WAIT_B  = 2'b01,
      WAIT_OP = 2'b10,
      DONE    = 2'b11
   } state_t;

   logic [2:0]       sync_a;
   logic [2:0]       sync_b;
   logic [2:0]       level;
   logic [2:0]       level_d;
   logic [CNT_W-1:0] cnt [3];
   logic [2:0]       strobe;

   state_t state;
   state_t next_state;
   logic   load_a;
   logic   load_b;
   logic   load_op;

   // Synchronize, then debounce: a level flips only after DBNC_CYCLES
   // consecutive samples disagree with it; any agreeing sample restarts.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_a  <= '0;
         sync_b  <= '0;
         level   <= '0;
         level_d <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         sync_a  <= i_btn;
         sync_b  <= sync_a;
         level_d <= level;
         for (int i = 0; i < 3; i++) begin
            if (sync_b[i] != level[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  level[i] <= ~level[i];
                  cnt[i]   <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   // Combinational strobe so the load lands one edge after the level rises.
   assign strobe = level & ~level_d;

   always_comb begin
      next_state = state;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_op    = 1'b0;
      case (state)
         WAIT_A: begin
            if (strobe[0]) begin
               load_a     = 1'b1;
               next_state = WAIT_B;
            end
         end
         WAIT_B: begin
            if (strobe[1]) begin
               load_b     = 1'b1;
               next_state = WAIT_OP;
            end
         end
         WAIT_OP: begin
            if (strobe[2]) begin
               load_op    = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            // Lower button index wins; losing strobes are dropped.
            if (strobe[0])      load_a  = 1'b1;
            else if (strobe[1]) load_b  = 1'b1;
            else if (strobe[2]) load_op = 1'b1;
         end
         default: next_state = WAIT_A;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= WAIT_A;
         o_data_a <= '0;
         o_data_b <= '0;
         o_op     <= '0;
         o_ready  <= 1'b0;
         o_load   <= 1'b0;
      end else begin
         state   <= next_state;
         o_ready <= (next_state == DONE);
         o_load  <= load_a | load_b | load_op;
         if (load_a)  o_data_a <= i_sw_data;
         if (load_b)  o_data_b <= i_sw_data;
         if (load_op) o_op     <= i_sw_op;
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Scoreboard bench for alu_load_sequencer with a short debounce window.
module tb_alu_load_sequencer;

   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;
   localparam int DBNC    = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [2:0]         btn = '0;
   logic [NB_DATA-1:0] sw_data = '0;
   logic [NB_OP-1:0]   sw_op = '0;
   logic [NB_DATA-1:0] data_a;
   logic [NB_DATA-1:0] data_b;
   logic [NB_OP-1:0]   op;
   logic [1:0]         state;
   logic               ready;
   logic               load;

   alu_load_sequencer #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .DBNC_CYCLES(DBNC)) dut (
      .clk(clk), .i_rst_n(rst_n), .i_btn(btn), .i_sw_data(sw_data), .i_sw_op(sw_op),
      .o_data_a(data_a), .o_data_b(data_b), .o_op(op), .o_state(state),
      .o_ready(ready), .o_load(load)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NB_DATA-1:0] a;
      logic [NB_DATA-1:0] b;
      logic [NB_OP-1:0]   op;
      logic [1:0]         st;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad = 0;
   int loads_seen = 0;
   int loads_exp = 0;

   logic [NB_DATA-1:0] mdl_a = '0;
   logic [NB_DATA-1:0] mdl_b = '0;
   logic [NB_OP-1:0]   mdl_op = '0;
   logic [1:0]         mdl_st = 2'b00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference FSM: decides which strobe (if any) is accepted and queues the result.
   task automatic model_press(input logic [2:0] mask);
      logic hit;
      hit = 1'b0;
      case (mdl_st)
         2'b00: if (mask[0]) begin mdl_a = sw_data; mdl_st = 2'b01; hit = 1'b1; end
         2'b01: if (mask[1]) begin mdl_b = sw_data; mdl_st = 2'b10; hit = 1'b1; end
         2'b10: if (mask[2]) begin mdl_op = sw_op; mdl_st = 2'b11; hit = 1'b1; end
         default: begin
            if (mask[0])      begin mdl_a = sw_data; hit = 1'b1; end
            else if (mask[1]) begin mdl_b = sw_data; hit = 1'b1; end
            else if (mask[2]) begin mdl_op = sw_op;  hit = 1'b1; end
         end
      endcase
      if (hit) begin
         exp_q.push_back('{a: mdl_a, b: mdl_b, op: mdl_op, st: mdl_st});
         loads_exp++;
      end
   endtask

   task automatic press(input logic [2:0] mask, input int hold);
      model_press(mask);
      btn = btn | mask;
      tick(hold);
      btn = btn & ~mask;
      tick(12);
   endtask

   // Press one button and count rising edges until its register shows val.
   task automatic press_timed(input string tag, input int idx, input logic [7:0] val);
      int n;
      logic [7:0] cur;
      model_press(3'b001 << idx);
      btn[idx] = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         cur = (idx == 0) ? data_a : (idx == 1) ? data_b : {2'b00, op};
      end while (cur != val && n < 30);
      chk(tag, n, DBNC + 3);
      tick(5);
      btn[idx] = 1'b0;
      tick(12);
   endtask

   task automatic model_reset();
      mdl_a = '0; mdl_b = '0; mdl_op = '0; mdl_st = 2'b00;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && load === 1'b1) begin
         loads_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_load", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ld_a", data_a, e.a);
            chk("ld_b", data_b, e.b);
            chk("ld_op", op, e.op);
            chk("ld_state", state, e.st);
            chk("ld_ready", ready, (e.st == 2'b11));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tick(3);
      chk("rst_a", data_a, 0);
      chk("rst_b", data_b, 0);
      chk("rst_op", op, 0);
      chk("rst_state", state, 0);
      chk("rst_ready", ready, 0);
      chk("rst_load", load, 0);
      rst_n = 1'b1;
      tick(3);

      // Out-of-order buttons in WAIT_A are ignored.
      sw_data = 8'h5C; sw_op = 6'h15;
      press(3'b010, 10);
      press(3'b100, 10);
      chk("ign_state", state, 2'b00);
      chk("ign_a", data_a, 0);
      chk("ign_b", data_b, 0);
      chk("ign_op", op, 0);

      // Normal load sequence with edge-accurate latency.
      sw_data = 8'h12;
      press_timed("lat_a", 0, 8'h12);
      chk("st_after_a", state, 2'b01);
      sw_data = 8'h34;
      press_timed("lat_b", 1, 8'h34);
      chk("st_after_b", state, 2'b10);
      sw_op = 6'h20;
      press_timed("lat_op", 2, 8'h20);
      chk("st_done", state, 2'b11);
      chk("ready_done", ready, 1);

      // Bouncing button: only the final stable rise loads.
      sw_data = 8'h56;
      for (int i = 0; i < 5; i++) begin
         btn[0] = 1'b1; tick(2);
         btn[0] = 1'b0; tick(2);
      end
      chk("bounce_a", data_a, 8'h12);
      press_timed("lat_bounce", 0, 8'h56);

      // Simultaneous btn0/btn1 in DONE: only A reloads.
      sw_data = 8'hAA;
      press(3'b011, 10);
      chk("simul_a", data_a, 8'hAA);
      chk("simul_b", data_b, 8'h34);

      // Long hold gives one load; re-press gives another.
      sw_data = 8'h77;
      press(3'b001, 50);
      sw_data = 8'h88;
      press(3'b001, 10);
      chk("repress_a", data_a, 8'h88);
      chk("done_ready", ready, 1);

      // Reset in WAIT_OP with btn2 mid-debounce.
      rst_n = 1'b0; model_reset(); tick(2);
      rst_n = 1'b1; tick(2);
      sw_data = 8'h11; press(3'b001, 10);
      sw_data = 8'h22; press(3'b010, 10);
      chk("pre_rst_state", state, 2'b10);
      sw_op = 6'h3F;
      btn[2] = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("async_a", data_a, 0);
      chk("async_b", data_b, 0);
      chk("async_state", state, 0);
      btn[2] = 1'b0;
      model_reset();
      tick(2);
      rst_n = 1'b1;
      tick(20);
      chk("post_rst_op", op, 0);
      chk("post_rst_state", state, 0);
      chk("post_rst_ready", ready, 0);

      chk("pending", exp_q.size(), 0);
      chk("load_count", loads_seen, loads_exp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_load_sequencer.md
ALU_LOAD_SEQUENCER -- requirements
Module: alu_load_sequencer

Interface
REQ-001 Parameter NB_DATA, default 8, operand width.
REQ-002 Parameter NB_OP, default 6, opcode width.
REQ-003 Parameter DBNC_CYCLES, default 1000000, consecutive stable cycles required for a debounced button change; legal range 2..2^24-1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_btn  input  3  raw asynchronous buttons: [0] load A, [1] load B, [2] load op.
REQ-007 i_sw_data  input  NB_DATA  operand switches, sampled directly at load edge.
REQ-008 i_sw_op  input  NB_OP  opcode switches, sampled directly at load edge.
REQ-009 o_data_a  output  NB_DATA  registered operand A to ALU.
REQ-010 o_data_b  output  NB_DATA  registered operand B to ALU.
REQ-011 o_op  output  NB_OP  registered opcode to ALU.
REQ-012 o_state  output  2  current FSM state encoding.
REQ-013 o_ready  output  1  high while A, B and op have all been loaded since reset.
REQ-014 o_load  output  1  one-cycle pulse, the cycle after any of o_data_a/o_data_b/o_op changes by a load.

Function
REQ-015 Each i_btn bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-016 Per button, a debounced level SHALL toggle only after the synchronized value differs from it for DBNC_CYCLES consecutive cycles; any equal sample clears that button's counter.
REQ-017 A one-cycle press strobe SHALL be generated on each 0->1 transition of a debounced level; 1->0 transitions generate nothing.
REQ-018 For a clean press, the selected output register SHALL update at exactly the (DBNC_CYCLES+3)th rising edge after i_btn goes high.
REQ-019 FSM states: WAIT_A=2'b00, WAIT_B=2'b01, WAIT_OP=2'b10, DONE=2'b11; o_state SHALL equal the state register.
REQ-020 WAIT_A: strobe0 loads o_data_a from i_sw_data, -> WAIT_B; strobes 1/2 ignored.
REQ-021 WAIT_B: strobe1 loads o_data_b, -> WAIT_OP; strobes 0/2 ignored.
REQ-022 WAIT_OP: strobe2 loads o_op from i_sw_op, -> DONE; strobes 0/1 ignored.
REQ-023 DONE: any strobe reloads its own register; state stays DONE; o_ready stays 1.
REQ-024 Simultaneous strobes in one cycle: only the highest-priority accepted strobe (0 > 1 > 2) acts; others SHALL be discarded, not queued.
REQ-025 Ignored or discarded strobes SHALL NOT change any output and SHALL NOT assert o_load.
REQ-026 o_ready SHALL be registered and equal (state == DONE).
REQ-027 o_load SHALL assert for exactly one cycle following every accepted load, including reloads in DONE.
REQ-028 A button held continuously SHALL produce one strobe only; repeat requires release (debounced 0) then press.

Reset
REQ-029 While i_rst_n=0: o_data_a=0, o_data_b=0, o_op=0, state=WAIT_A, o_ready=0, o_load=0, synchronizers, debounced levels and counters all 0, asynchronously.
REQ-030 Reset asserted mid-debounce or mid-sequence SHALL discard all progress; after release, a button already held SHALL be treated as a new press (REQ-018 timing from release).

Verification (DBNC_CYCLES=4)
REQ-031 Reset, sw_data=8'h12 press btn0, sw_data=8'h34 press btn1, sw_op=6'h20 press btn2 -> A=12,B=34,op=20, o_state 00->01->10->11, o_ready=1, three o_load pulses; btn0 update at edge 7 after press.
REQ-032 In WAIT_A, press btn1 then btn2 -> no output change, no o_load, o_state=00.
REQ-033 btn0 toggled every 2 cycles for 20 cycles then held high -> exactly one load, occurring 7 edges after final rise.
REQ-034 In DONE, btn0 and btn1 rise same cycle with sw_data=8'hAA -> only A=AA, B unchanged, single o_load.
REQ-035 Reset pulsed while in WAIT_OP with btn2 mid-debounce -> all outputs 0, o_state=00, no load after release.
REQ-036 btn0 held 50 cycles -> one strobe; release 10 cycles, press again -> second load.
